// File: rtl/key_event_capture.sv
// Key event capture: debounces the active-low code from the priority encoder,
// turns each accepted press into an event and queues it for a valid/ready consumer.
module key_event_capture #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    Y_n,
  input  logic                          key_ready,
  input  logic                          clr_ovf,
  output logic [3:0]                    key_code,
  output logic                          key_valid,
  output logic                          key_held,
  output logic                          key_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam logic [7:0]    DEB_C  = 8'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESSED = 1'b1;

  logic [3:0]    y_q_r;
  logic [3:0]    key_raw_s;
  logic [3:0]    key_s;
  logic [3:0]    cand_r;
  logic [7:0]    cnt_r;
  logic [3:0]    stable_key_r;
  logic [0:0]    state_r;
  logic          qualified_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          push_ok_s;
  logic          drop_s;
  logic [3:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] rd_next_s;
  logic [CW-1:0] fifo_cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic [3:0]    head_next_s;
  logic [3:0]    key_code_r;
  logic          key_valid_r;
  logic          key_ovf_r;

  // Decode the sampled code; codes above 9 cannot come from the encoder and read as no key.
  always_comb begin
    key_raw_s = ~y_q_r;
    if (key_raw_s > 4'd9) begin
      key_s = 4'd0;
    end else begin
      key_s = key_raw_s;
    end
  end

  assign qualified_s = (cnt_r == DEB_C) && (cand_r != stable_key_r);
  assign push_s      = qualified_s && (cand_r != 4'd0);
  assign pop_s       = key_valid_r && key_ready;
  assign full_s      = (fifo_cnt_r == FULL_C);
  assign push_ok_s   = push_s && (!full_s || pop_s);
  assign drop_s      = push_s && full_s && !pop_s;

  // Input sampling, debounce counter and press/release state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_r        <= 4'hF;
      cand_r       <= 4'd0;
      cnt_r        <= 8'd0;
      stable_key_r <= 4'd0;
      state_r      <= ST_IDLE;
    end else begin
      y_q_r <= Y_n;
      if (key_s != cand_r) begin
        cand_r <= key_s;
        cnt_r  <= 8'd1;
      end else if (cnt_r < DEB_C) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (qualified_s) begin
        stable_key_r <= cand_r;
        state_r      <= (cand_r != 4'd0) ? ST_PRESSED : ST_IDLE;
      end else begin
        stable_key_r <= stable_key_r;
        state_r      <= state_r;
      end
    end
  end

  // Next occupancy and next head; a push landing on the new head slot bypasses the array.
  always_comb begin
    rd_next_s = pop_s ? (rd_ptr_r + 1'b1) : rd_ptr_r;
    case ({push_ok_s, pop_s})
      2'b10:   cnt_next_s = fifo_cnt_r + 1'b1;
      2'b01:   cnt_next_s = fifo_cnt_r - 1'b1;
      default: cnt_next_s = fifo_cnt_r;
    endcase
    if (cnt_next_s == {CW{1'b0}}) begin
      head_next_s = 4'd0;
    end else if (push_ok_s && (wr_ptr_r == rd_next_s)) begin
      head_next_s = cand_r;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // Event queue storage, pointers, registered head view and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 4'd0;
      end
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      fifo_cnt_r  <= {CW{1'b0}};
      key_code_r  <= 4'd0;
      key_valid_r <= 1'b0;
      key_ovf_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= cand_r;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r    <= rd_next_s;
      fifo_cnt_r  <= cnt_next_s;
      key_code_r  <= head_next_s;
      key_valid_r <= (cnt_next_s != {CW{1'b0}});
      if (drop_s) begin
        key_ovf_r <= 1'b1;
      end else if (clr_ovf) begin
        key_ovf_r <= 1'b0;
      end else begin
        key_ovf_r <= key_ovf_r;
      end
    end
  end

  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_held  = (state_r == ST_PRESSED);
  assign key_ovf   = key_ovf_r;
  assign fifo_cnt  = fifo_cnt_r;

endmodule

// File: tb/tb_key_event_capture.sv
// Bench for key_event_capture: directed scenarios plus randomized key activity,
// compared every cycle against a sliding-window / queue reference model.
module tb_key_event_capture;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] Y_n;
  logic       key_ready;
  logic       clr_ovf;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       key_ovf;
  logic [2:0] fifo_cnt;

  key_event_capture #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .Y_n(Y_n), .key_ready(key_ready), .clr_ovf(clr_ovf),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
    .key_ovf(key_ovf), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: last DEB decoded samples, accepted key, event queue.
  int         m_hist[$];
  logic [3:0] m_prev_y;
  int         m_stable;
  bit         m_held;
  bit         m_ovf;
  int         m_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic int to_key(input logic [3:0] y);
    logic [3:0] k;
    k = ~y;
    return (k > 4'd9) ? 0 : int'(k);
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_q.delete();
    m_prev_y = 4'hF;
    m_stable = 0;
    m_held   = 1'b0;
    m_ovf    = 1'b0;
  endtask

  // One clock edge: a key is accepted once the last DEB decoded samples agree.
  task automatic model_step();
    int  ks;
    int  v;
    bit  all_eq;
    bit  push;
    bit  pop;
    bit  drop;
    ks   = to_key(m_prev_y);
    push = 1'b0;
    v    = 0;
    if (m_hist.size() == DEB) begin
      v = m_hist[DEB-1];
      all_eq = 1'b1;
      foreach (m_hist[i]) if (m_hist[i] != v) all_eq = 1'b0;
      if (all_eq && v != m_stable) begin
        m_stable = v;
        m_held   = (v != 0);
        push     = (v != 0);
      end
    end
    m_hist.push_back(ks);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    pop  = (m_q.size() > 0) && key_ready;
    drop = push && (m_q.size() == DEPTH) && !pop;
    if (pop) void'(m_q.pop_front());
    if (push && !drop) m_q.push_back(v);
    if (drop) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    m_prev_y = Y_n;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"}, key_valid, (m_q.size() > 0) ? 1 : 0);
    check({tag, ".code"},  key_code,  (m_q.size() > 0) ? m_q[0] : 0);
    check({tag, ".cnt"},   fifo_cnt,  m_q.size());
    check({tag, ".held"},  key_held,  m_held);
    check({tag, ".ovf"},   key_ovf,   m_ovf);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_model(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".z_valid"}, key_valid, 0);
    check({tag, ".z_code"},  key_code,  0);
    check({tag, ".z_cnt"},   fifo_cnt,  0);
    check({tag, ".z_held"},  key_held,  0);
    check({tag, ".z_ovf"},   key_ovf,   0);
  endtask

  // Asserts reset just after an edge, holds it across one edge, then releases.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic hold(input logic [3:0] y, input int n, input string tag);
    Y_n = y;
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    Y_n       = 4'hF;
    key_ready = 1'b0;
    clr_ovf   = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single press of key 9: accepted after edge DEB+2, exactly one event.
    Y_n = 4'b0110;
    for (int c = 1; c <= 10; c++) begin
      tick("t1");
      if (c == DEB + 1) check("t1.valid_early", key_valid, 0);
      if (c == DEB + 2) begin
        check("t1.valid_rise", key_valid, 1);
        check("t1.code", key_code, 9);
        check("t1.held", key_held, 1);
      end
    end
    check("t1.one_event", fifo_cnt, 1);
    key_ready = 1'b1;
    hold(4'hF, 8, "t1drain");
    key_ready = 1'b0;

    // Short glitch never accepted.
    hold(4'b1100, 3, "t2");
    hold(4'hF, 8, "t2");
    check("t2.no_event", key_valid, 0);
    check("t2.no_held", key_held, 0);

    // Rollover 3 -> 7 without release, then release.
    hold(~4'd3, 8, "t3");
    hold(~4'd7, 8, "t3");
    check("t3.cnt", fifo_cnt, 2);
    check("t3.head", key_code, 3);
    hold(4'hF, 8, "t3");
    check("t3.released", key_held, 0);
    check("t3.cnt_rel", fifo_cnt, 2);
    key_ready = 1'b1;
    tick("t3pop");
    check("t3.second", key_code, 7);
    tick("t3pop");
    key_ready = 1'b0;

    // Fill beyond depth: fifth press dropped.
    hold(~4'd1, 7, "t4"); hold(4'hF, 7, "t4");
    hold(~4'd2, 7, "t4"); hold(4'hF, 7, "t4");
    hold(~4'd4, 7, "t4"); hold(4'hF, 7, "t4");
    hold(~4'd5, 7, "t4"); hold(4'hF, 7, "t4");
    hold(~4'd6, 7, "t4"); hold(4'hF, 7, "t4");
    check("t4.full", fifo_cnt, 4);
    check("t4.ovf", key_ovf, 1);
    check("t4.head", key_code, 1);
    clr_ovf = 1'b1;
    tick("t4clr");
    clr_ovf = 1'b0;
    check("t4.ovf_clr", key_ovf, 0);

    // Full queue: pop coincides with the push edge of key 8.
    hold(~4'd8, DEB + 1, "t5");
    key_ready = 1'b1;
    tick("t5push");
    check("t5.cnt", fifo_cnt, 4);
    check("t5.ovf", key_ovf, 0);
    check("t5.head", key_code, 2);
    tick("t5d"); check("t5.d1", key_code, 4);
    tick("t5d"); check("t5.d2", key_code, 5);
    tick("t5d"); check("t5.d3", key_code, 8);
    tick("t5d"); check("t5.empty", key_valid, 0);
    key_ready = 1'b0;
    hold(4'hF, 8, "t5");

    // Reset while two events queued and a key held; held key re-reported.
    hold(~4'd3, 7, "t6"); hold(4'hF, 7, "t6");
    hold(~4'd9, 7, "t6");
    check("t6.pre_cnt", fifo_cnt, 2);
    pulse_reset("t6");
    for (int c = 1; c <= DEB + 2; c++) begin
      tick("t6re");
      if (c == DEB + 1) check("t6.early", key_valid, 0);
    end
    check("t6.rereport", key_valid, 1);
    check("t6.code", key_code, 9);
    check("t6.cnt", fifo_cnt, 1);

    // Randomized key activity, consumer backpressure and overflow clears.
    for (int seg = 0; seg < 400; seg++) begin
      int r;
      int len;
      r = $urandom_range(0, 15);
      if (r < 10) Y_n = ~(4'(r));
      else Y_n = 4'($urandom_range(0, 5));
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        key_ready = ($urandom_range(0, 3) == 0);
        clr_ovf   = ($urandom_range(0, 19) == 0);
        tick("rnd");
      end
      if (seg % 97 == 96) pulse_reset("rnd_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
